// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encoding,
// default timing, frame layout and common keyboard command codes.
package ps2_host_tx_pkg;

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 10;

  localparam int unsigned DEF_INHIBIT_CYCLES = 6000;    // 120 us at 50 MHz
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz
  localparam int unsigned DEF_FILTER_LEN     = 8;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // bitcnt value seen at the falling edge that puts the stop bit on the line
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(9);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_SEND      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } frame_t;

  // Frame shifted out LSB first: data, odd parity, stop.
  function automatic frame_t make_frame(input logic [7:0] data);
    frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between a bus-mapped requester and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_ack_ok, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_ack_ok, tx_error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for a PS/2 line; emits a
// one-cycle strobe when the filtered level goes 1 -> 0.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q;
  logic [RUN_W-1:0] run_q;
  logic             level_q;
  logic             fall_q;

  // A new level is adopted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      run_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        run_q <= '0;
      end else if (run_q == RUN_LAST) begin
        run_q   <= '0;
        level_q <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        run_q <= run_q + RUN_W'(1);
      end
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit,
// shifts a command frame on device clock edges, then collects the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic         CLOCK_50,
  input  logic         KEY0,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_drive_low,
  output logic         ps2_dat_drive_low
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic               clk_level;
  logic               clk_fall;
  logic [1:0]         dat_sync_q;
  logic               dat_sync;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BIT_W-1:0]   bitcnt, bitcnt_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic               ack, ack_n;
  logic               done_ev, err_ev;

  logic ready_q, busy_q, done_q, ack_ok_q, err_q, clk_low_q, dat_low_q;
  logic ready_n, busy_n, clk_low_n, dat_low_n;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .pin   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  // Data line needs only synchronizing; it is sampled on filtered clock events.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) dat_sync_q <= 2'b11;
    else       dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
  end
  assign dat_sync = dat_sync_q[1];

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      ack       <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= 1'b0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      ack       <= ack_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      done_q    <= done_ev;
      ack_ok_q  <= done_ev & ack;
      err_q     <= err_ev;
      clk_low_q <= clk_low_n;
      dat_low_q <= dat_low_n;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    ack_n    = ack;
    done_ev  = 1'b0;
    err_ev   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.tx_valid && ready_q) begin
          state_n  = ST_INHIBIT;
          shreg_n  = make_frame(bus.tx_data);
          bitcnt_n = '0;
          cnt_n    = '0;
        end
      end
      ST_INHIBIT: begin
        if (cnt == INHIBIT_LAST) begin
          state_n = ST_SEND;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          shreg_n  = {1'b0, shreg[FRAME_W-1:1]};
          bitcnt_n = bitcnt + BIT_W'(1);
          if (bitcnt == LAST_BIT) state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          ack_n   = ~dat_sync;
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && dat_sync) begin
          done_ev = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Device-silence watchdog; a falling edge in the same cycle wins.
    if (state inside {ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
      if (clk_fall) begin
        cnt_n = '0;
      end else if (cnt == TIMEOUT_LAST && !done_ev) begin
        err_ev  = 1'b1;
        state_n = ST_IDLE;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  // Output values for the next cycle.
  always_comb begin
    ready_n   = (state_n == ST_IDLE) && !done_ev && !err_ev;
    busy_n    = ~ready_n;
    clk_low_n = (state_n == ST_INHIBIT);
    dat_low_n = dat_low_q;
    if (state == ST_SEND && clk_fall) dat_low_n = ~shreg[0];
    // Start bit goes out in the final inhibit cycle.
    if (state_n == ST_INHIBIT)        dat_low_n = (cnt_n == INHIBIT_LAST);
    if (state_n == ST_IDLE)           dat_low_n = 1'b0;
  end

  assign bus.tx_ready      = ready_q;
  assign bus.busy          = busy_q;
  assign bus.tx_done       = done_q;
  assign bus.tx_ack_ok     = ack_ok_q;
  assign bus.tx_error      = err_q;
  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks frames off the wired
// lines, expectations are queued at request time and checked on done/error.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH = 60;
  localparam int unsigned TMO = 2000;
  localparam int unsigned FL  = 8;
  localparam int unsigned HP  = 40;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         ack;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic KEY0     = 1'b0;
  logic dev_clk  = 1'b1;
  logic dev_dat  = 1'b1;
  logic glitch   = 1'b0;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_drive_low, ps2_dat_drive_low;

  int unsigned cyc      = 0;
  int unsigned send_cyc = 0;
  int vectors     = 0;
  int miscompares = 0;

  exp_t       exp_q[$];
  logic [9:0] rx_q[$];

  ps2_host_tx_if bus();

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Open-drain wired-AND of host, device and injected glitches.
  assign ps2_clk_in = dev_clk & ~ps2_clk_drive_low & ~glitch;
  assign ps2_dat_in = dev_dat & ~ps2_dat_drive_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FL)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .KEY0              (KEY0),
    .bus               (bus),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_dat_in        (ps2_dat_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ref_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic send_request(input logic [7:0] d, output bit ok);
    int k = 0;
    @(negedge CLOCK_50);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (!bus.tx_ready && k < 4000) begin
      @(negedge CLOCK_50);
      k++;
    end
    ok = bus.tx_ready;
    @(negedge CLOCK_50);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Measures the clock inhibit and start-bit timing; returns at the first SEND cycle.
  task automatic wait_inhibit(output bit ok);
    int n = 0;
    int dat_first = -1;
    int w = 0;
    ok = 1'b0;
    while (!ps2_clk_drive_low && w < 100) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (!ps2_clk_drive_low) begin
      check("inhibit_start", 0, 1);
      return;
    end
    while (ps2_clk_drive_low && n < int'(INH) + 10) begin
      n++;
      if (ps2_dat_drive_low && dat_first < 0) dat_first = n;
      @(negedge CLOCK_50);
    end
    check("inhibit_len", 32'(n), INH);
    check("start_bit_cycle", 32'(dat_first), INH);
    check("start_bit_held", 32'(ps2_dat_drive_low), 1);
    send_cyc = cyc;
    ok = 1'b1;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!bus.tx_ready && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (!bus.tx_ready) check("ready_timeout", 0, 1);
  endtask

  // Device side: 11 clock pulses, reading each bit just before the rising edge.
  task automatic dev_clock(input bit do_ack, input bit glitchy, input int stop_after);
    logic [9:0] bits = '0;
    repeat (HP / 2) @(negedge CLOCK_50);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11) dev_dat = ~do_ack;
      dev_clk = 1'b0;
      if (e == 5) begin
        check("busy_mid", 32'(bus.busy), 1);
        check("ready_mid", 32'(bus.tx_ready), 0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'($urandom);
      end
      repeat (HP) @(negedge CLOCK_50);
      bus.tx_valid = 1'b0;
      if (e <= 10) bits[e-1] = ps2_dat_in;
      if (e == 10) rx_q.push_back(bits);
      dev_clk = 1'b1;
      if (e == stop_after) return;
      if (glitchy && (e == 3 || e == 6)) begin
        repeat (HP / 2) @(negedge CLOCK_50);
        glitch = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        glitch = 1'b0;
        repeat (HP - HP / 2 - 3) @(negedge CLOCK_50);
      end else begin
        repeat (HP) @(negedge CLOCK_50);
      end
    end
    dev_dat = 1'b1;
  endtask

  task automatic run_transfer(input logic [7:0] d, input bit do_ack, input bit glitchy);
    bit   ok;
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.ack    = do_ack;
    exp_q.push_back(e);
    send_request(d, ok);
    if (!ok) return;
    wait_inhibit(ok);
    if (!ok) return;
    dev_clock(do_ack, glitchy, 0);
    wait_ready(3 * int'(TMO));
  endtask

  task automatic run_timeout(input logic [7:0] d);
    bit   ok;
    exp_t e;
    e.is_err = 1'b1;
    e.data   = d;
    e.ack    = 1'b0;
    exp_q.push_back(e);
    send_request(d, ok);
    if (!ok) return;
    wait_inhibit(ok);
    if (!ok) return;
    wait_ready(2 * int'(TMO));
  endtask

  task automatic run_reset_midway(input logic [7:0] d);
    bit ok;
    send_request(d, ok);
    if (!ok) return;
    wait_inhibit(ok);
    if (!ok) return;
    dev_clock(1'b1, 1'b0, 4);
    #3 KEY0 = 1'b0;
    #1;
    check("reset_clk_release", 32'(ps2_clk_drive_low), 0);
    check("reset_dat_release", 32'(ps2_dat_drive_low), 0);
    check("reset_ready", 32'(bus.tx_ready), 1);
    check("reset_busy", 32'(bus.busy), 0);
    repeat (5) @(negedge CLOCK_50);
    KEY0    = 1'b1;
    dev_dat = 1'b1;
  endtask

  // Monitor: pops an expectation for every done/error pulse.
  initial begin : monitor
    exp_t       e;
    logic [9:0] f;
    forever begin
      @(negedge CLOCK_50);
      if (bus.tx_done || bus.tx_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({bus.tx_done, bus.tx_error}), 0);
        end else begin
          e = exp_q.pop_front();
          check("error_pulse", 32'(bus.tx_error), 32'(e.is_err));
          check("done_pulse", 32'(bus.tx_done), 32'(!e.is_err));
          check("ready_in_event_cycle", 32'(bus.tx_ready), 0);
          if (!e.is_err) begin
            check("ack_ok", 32'(bus.tx_ack_ok), 32'(e.ack));
            if (rx_q.size() == 0) begin
              check("wire_frame_present", 0, 1);
            end else begin
              f = rx_q.pop_front();
              check("wire_frame", 32'(f), 32'({1'b1, ref_parity(e.data), e.data}));
            end
          end else begin
            check("timeout_latency", cyc - send_cyc, TMO);
            check("release_on_error", 32'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
          end
          @(negedge CLOCK_50);
          check("ready_after_event", 32'(bus.tx_ready), 1);
          check("busy_after_event", 32'(bus.busy), 0);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge CLOCK_50);
    $display("FAIL watchdog: run exceeded 80000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    check("rst_clk_drive", 32'(ps2_clk_drive_low), 0);
    check("rst_dat_drive", 32'(ps2_dat_drive_low), 0);
    check("rst_ready", 32'(bus.tx_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.tx_done), 0);
    check("rst_ack_ok", 32'(bus.tx_ack_ok), 0);
    check("rst_error", 32'(bus.tx_error), 0);
    KEY0 = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    run_transfer(CMD_SET_LEDS, 1'b1, 1'b0);
    run_transfer(8'h00, 1'b1, 1'b0);
    run_transfer(CMD_RESET, 1'b1, 1'b0);
    run_transfer(8'h5A, 1'b0, 1'b0);
    run_timeout(8'h81);
    run_transfer(8'hA7, 1'b1, 1'b1);
    run_reset_midway(8'h3C);
    run_transfer(CMD_ENABLE, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_transfer(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (20) @(negedge CLOCK_50);
    check("pending_expected", 32'(exp_q.size()), 0);
    check("pending_frames", 32'(rx_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
